// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
//
// N-master to 1-slave arbiter for the SRAM-like (req / addr_ok / data_ok)
// memory interface. One slave port is shared by NUM_M masters. Master 0 is the
// fetch port by convention.
//
// Grant policy
//   - Round-robin search starting at rr_ptr. The search runs upward, modulo NUM_M.
//   - Once a request has been presented and not accepted, the grant is locked to
//     that master until the handshake completes. The slave therefore never sees
//     a presented request change underneath it.
//   - When the outstanding limit is reached, s_req drops but the lock is kept.
//     The locked master is presented again first once a slot frees up.
//
// Response routing
//   - The index of every accepted request is pushed into a small tag FIFO.
//   - The slave answers in order, so the FIFO head names the master that owns
//     each s_data_ok. Writes get a data_ok as well.
//
// Handshake semantics
//   - A request transfers on a cycle with s_req & s_addr_ok.
//   - m_addr_ok echoes that transfer to the granted master.
//   - A response transfers on a cycle with s_data_ok while a tag is outstanding.
//   - Neither side uses a ready-before-valid dependency. s_req depends only on
//     registered state and the m_req inputs, never on s_data_ok.
//
// Ports
//   clk, resetn    clock, synchronous active-low reset
//   m_req/m_wr     per-master request / write flag        [NUM_M]
//   m_size         per-master size, master i at [2i+:2]   [2*NUM_M]
//   m_addr         per-master address, packed             [ADDR_W*NUM_M]
//   m_wstrb        per-master byte strobes, packed        [DATA_W/8*NUM_M]
//   m_wdata        per-master write data, packed          [DATA_W*NUM_M]
//   m_addr_ok      request accepted this cycle (one-hot or zero)
//   m_data_ok      response for this master (one-hot or zero)
//   m_rdata        shared read data, valid with m_data_ok
//   s_req..s_wdata slave request channel, muxed from the granted master
//   s_addr_ok      slave accepts the request
//   s_data_ok      slave returns a response (in order)
//   s_rdata        slave read data
//   outs_cnt       accepted-but-unanswered request count (0..MAX_OUTS)
//   err_orphan     sticky: s_data_ok arrived with nothing outstanding
// -----------------------------------------------------------------------------
module sram_like_arbiter #(
  parameter int NUM_M    = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_OUTS = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_M-1:0]              m_req,
  input  logic [NUM_M-1:0]              m_wr,
  input  logic [2*NUM_M-1:0]            m_size,
  input  logic [ADDR_W*NUM_M-1:0]       m_addr,
  input  logic [DATA_W/8*NUM_M-1:0]     m_wstrb,
  input  logic [DATA_W*NUM_M-1:0]       m_wdata,
  output logic [NUM_M-1:0]              m_addr_ok,
  output logic [NUM_M-1:0]              m_data_ok,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_wr,
  output logic [1:0]                    s_size,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W/8-1:0]           s_wstrb,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_addr_ok,
  input  logic                          s_data_ok,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [$clog2(MAX_OUTS):0]     outs_cnt,
  output logic                          err_orphan
);

  localparam int STRB_W = DATA_W / 8;
  // A single master still needs a 1-bit index so the tag FIFO stays well formed.
  localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int PTR_W  = $clog2(MAX_OUTS);
  localparam int CNT_W  = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] rr_ptr;
  logic             lock;
  logic [IDX_W-1:0] locked_idx;
  logic [IDX_W-1:0] tag_mem [MAX_OUTS];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             orphan_q;

  // ---------------------------------------------------------------------------
  // Combinational arbitration
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] rr_grant;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] rr_next;
  logic [IDX_W-1:0] head;
  logic             full;
  logic             empty;
  logic             hs;
  logic             pop;

  // full and empty come from registered state only. This keeps s_req free of
  // any path from s_data_ok.
  assign full  = (cnt_q == CNT_W'(MAX_OUTS));
  assign empty = (cnt_q == '0);

  // Round-robin search from rr_ptr, wrapping at NUM_M. NUM_M need not be a
  // power of 2, so the wrap is an explicit subtract rather than an overflow.
  always_comb begin
    int  idx;
    logic found;
    rr_grant = rr_ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (!found && m_req[idx]) begin
        found    = 1'b1;
        rr_grant = IDX_W'(idx);
      end
    end
  end

  assign grant = lock ? locked_idx : rr_grant;

  always_comb begin
    rr_next = '0;
    if (int'(grant) + 1 < NUM_M) rr_next = grant + 1'b1;
  end

  assign s_req = resetn & (lock | (|m_req)) & ~full;
  assign hs    = s_req & s_addr_ok;
  assign pop   = resetn & s_data_ok & ~empty;
  assign head  = tag_mem[rd_ptr];

  // Slave request fields follow the grant with zero-cycle latency.
  always_comb begin
    int gi;
    gi      = int'(grant);
    s_wr    = m_wr[gi];
    s_size  = m_size[gi*2 +: 2];
    s_addr  = m_addr[gi*ADDR_W +: ADDR_W];
    s_wstrb = m_wstrb[gi*STRB_W +: STRB_W];
    s_wdata = m_wdata[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int i = 0; i < NUM_M; i++) begin
      m_addr_ok[i] = hs  && (grant == IDX_W'(i));
      m_data_ok[i] = pop && (head  == IDX_W'(i));
    end
  end

  // Read data is shared; the owner is identified by m_data_ok.
  assign m_rdata    = s_rdata;
  assign outs_cnt   = cnt_q;
  assign err_orphan = orphan_q;

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr     <= '0;
      lock       <= 1'b0;
      locked_idx <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt_q      <= '0;
      orphan_q   <= 1'b0;
    end else begin
      // A presented but unaccepted request pins the grant. The lock is only
      // taken while s_req is high, so a full stall keeps whatever lock exists.
      if (hs) begin
        lock   <= 1'b0;
        rr_ptr <= rr_next;
      end else if (s_req) begin
        lock       <= 1'b1;
        locked_idx <= grant;
      end

      if (hs)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      // A push and a pop in the same cycle cancel out.
      case ({hs, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      if (s_data_ok && empty) orphan_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: the pointers and the count define its validity.
  // A push never hits a full FIFO, because hs requires ~full.
  always_ff @(posedge clk) begin
    if (hs) tag_mem[wr_ptr] <= grant;
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_addr_ok_onehot : assert property (@(posedge clk) disable iff (!resetn)
    $onehot0(m_addr_ok));
  a_data_ok_onehot : assert property (@(posedge clk) disable iff (!resetn)
    $onehot0(m_data_ok));
  a_cnt_bound : assert property (@(posedge clk) disable iff (!resetn)
    cnt_q <= CNT_W'(MAX_OUTS));

endmodule
